fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. It owns the PC and drives a single-outstanding-request instruction ROM handshake. It merges redirects (exception over jump) and drops stale in-flight responses after a redirect. It presents fetched instructions to the decode stage under a valid/stall handshake and flushes the IF/ID register on redirect.

---
 rtl/fetch_ctrl_pkg.sv | 35 +++
 rtl/fetch_wait_timer.sv | 39 +++
 rtl/fetch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Reset is active-low here, so RST_ENABLE is the level that resets.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

    localparam logic        RST_ENABLE  = 1'b0;
    localparam logic        ROM_ENABLE  = 1'b1;
    localparam logic        ROM_DISABLE = 1'b0;
    localparam logic        VALID       = 1'b1;
    localparam logic        INVALID     = 1'b0;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    // Exception redirects win over jumps when both arrive together.
    function automatic logic [31:0] redirect_target(
        input logic        exc_ce,
        input logic [31:0] exc_addr,
        input logic [31:0] j_addr
    );
        return exc_ce ? exc_addr : j_addr;
    endfunction

    function automatic logic [31:0] pc_advance(
        input logic [31:0] pc,
        input logic [31:0] step
    );
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts ROM wait cycles and flags when the limit is reached.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_wait_timer
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    assign expired = (cnt_reg == LIMIT);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = 4'd0;
        end else if (inc && !expired) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a single-outstanding ROM
// handshake, merges redirects and drops stale responses. FETCH_TIMEOUT_EN adds a wait timeout.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    input  logic        excCe,
    input  logic [31:0] excAddr,
    input  logic        stall,
    output logic        romCe,
    output logic [31:0] romAddr,
    input  logic        romReady,
    input  logic [31:0] romData,
    output logic        romAck,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        instValid,
    output logic        flush,
    output logic        fetchErr
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pend_pc_reg, pend_pc_next;
    logic [31:0]  inst_reg, inst_next;
    logic [31:0]  inst_pc_reg, inst_pc_next;
    logic         inst_valid_reg, inst_valid_next;
    logic         flush_reg, flush_next;
    logic         fetch_err_reg, fetch_err_next;
    logic         rom_ce;
    logic         rom_ack;

    logic         redir;
    logic [31:0]  tgt;
    logic         slot_free;
    logic         timeout;

    assign redir     = excCe | jCe;
    assign tgt       = redirect_target(excCe, excAddr, jAddr);
    assign slot_free = !inst_valid_reg || !stall;

`ifdef FETCH_TIMEOUT_EN
    logic timer_clr;
    logic timer_expired;

    // Clear on every consumed response and whenever we newly enter a waiting state.
    assign timer_clr = rom_ack ||
                       (((state_next == ST_REQ) || (state_next == ST_DROP)) &&
                        (state_next != state_reg));

    fetch_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .inc    (rom_ce && !romReady),
        .expired(timer_expired)
    );

    assign timeout = timer_expired && !romReady;
`else
    logic [3:0] unused_wait_limit;
    assign unused_wait_limit = 4'(WAIT_LIMIT);
    assign timeout           = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_pc_next    = pend_pc_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_valid_next = inst_valid_reg;
        flush_next      = 1'b0;
        fetch_err_next  = fetch_err_reg;
        rom_ce          = ROM_DISABLE;
        rom_ack         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
                if (redir) begin
                    pc_next    = tgt;
                    flush_next = 1'b1;
                end
            end

            ST_REQ: begin
                rom_ce = ROM_ENABLE;
                if (timeout) begin
                    state_next      = ST_ERR;
                    fetch_err_next  = 1'b1;
                    inst_valid_next = INVALID;
                end else if (redir) begin
                    flush_next      = 1'b1;
                    inst_valid_next = INVALID;
                    if (romReady) begin
                        rom_ack = 1'b1;
                        pc_next = tgt;
                    end else begin
                        // Request still in flight: remember target, discard it later.
                        pend_pc_next = tgt;
                        state_next   = ST_DROP;
                    end
                end else if (romReady) begin
                    if (slot_free) begin
                        rom_ack         = 1'b1;
                        inst_next       = romData;
                        inst_pc_next    = pc_reg;
                        inst_valid_next = VALID;
                        pc_next         = pc_advance(pc_reg, PC_STEP);
                    end
                end else if (slot_free) begin
                    inst_valid_next = INVALID;
                end
            end

            ST_DROP: begin
                rom_ce = ROM_ENABLE;
                if (timeout) begin
                    state_next      = ST_ERR;
                    fetch_err_next  = 1'b1;
                    inst_valid_next = INVALID;
                end else if (romReady) begin
                    rom_ack    = 1'b1;
                    pc_next    = redir ? tgt : pend_pc_reg;
                    flush_next = redir;
                    state_next = ST_REQ;
                end else if (redir) begin
                    pend_pc_next = tgt;
                    flush_next   = 1'b1;
                end
            end

`ifdef FETCH_TIMEOUT_EN
            ST_ERR: begin
                // Only an exception can recover; jumps are ignored here.
                if (excCe) begin
                    pc_next        = excAddr;
                    fetch_err_next = 1'b0;
                    flush_next     = 1'b1;
                    state_next     = ST_REQ;
                end
            end
`endif

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            pend_pc_reg    <= ZERO_WORD;
            inst_reg       <= ZERO_WORD;
            inst_pc_reg    <= ZERO_WORD;
            inst_valid_reg <= INVALID;
            flush_reg      <= 1'b0;
            fetch_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_pc_reg    <= pend_pc_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= inst_valid_next;
            flush_reg      <= flush_next;
            fetch_err_reg  <= fetch_err_next;
        end
    end

    assign romCe     = rom_ce;
    assign romAddr   = pc_reg;
    assign romAck    = rom_ack;
    assign inst      = inst_reg;
    assign instPc    = inst_pc_reg;
    assign instValid = inst_valid_reg;
    assign flush     = flush_reg;
`ifdef FETCH_TIMEOUT_EN
    assign fetchErr  = fetch_err_reg;
`else
    assign fetchErr  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-computed expectations checked by immediate assertions.
// The timeout section is compiled only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        jCe;
    logic [31:0] jAddr;
    logic        excCe;
    logic [31:0] excAddr;
    logic        stall;
    logic        romCe;
    logic [31:0] romAddr;
    logic        romReady;
    logic [31:0] romData;
    logic        romAck;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instValid;
    logic        flush;
    logic        fetchErr;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .jCe      (jCe),
        .jAddr    (jAddr),
        .excCe    (excCe),
        .excAddr  (excAddr),
        .stall    (stall),
        .romCe    (romCe),
        .romAddr  (romAddr),
        .romReady (romReady),
        .romData  (romData),
        .romAck   (romAck),
        .inst     (inst),
        .instPc   (instPc),
        .instValid(instValid),
        .flush    (flush),
        .fetchErr (fetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and settle for 1 time unit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] data, input logic stl,
                         input logic j, input logic [31:0] ja,
                         input logic e, input logic [31:0] ea);
        romReady = rdy;
        romData  = data;
        stall    = stl;
        jCe      = j;
        jAddr    = ja;
        excCe    = e;
        excAddr  = ea;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_romCe",     {31'd0, romCe},     32'd0);
        chk("rst_romAck",    {31'd0, romAck},    32'd0);
        chk("rst_romAddr",   romAddr,            32'h0);
        chk("rst_inst",      inst,               32'h0);
        chk("rst_instPc",    instPc,             32'h0);
        chk("rst_instValid", {31'd0, instValid}, 32'd0);
        chk("rst_flush",     {31'd0, flush},     32'd0);
        chk("rst_fetchErr",  {31'd0, fetchErr},  32'd0);
        $display("txn reset: romCe=%0b instValid=%0b flush=%0b", romCe, instValid, flush);

        rst = 1'b1;
        tick();  // IDLE -> REQ

        // Sequential fetch 0,4,8 with ROM answering every cycle.
        drive(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq0_romCe",   {31'd0, romCe},  32'd1);
        chk("seq0_romAddr", romAddr,         32'h0);
        chk("seq0_romAck",  {31'd0, romAck}, 32'd1);
        $display("txn fetch addr=%h", romAddr);
        tick();
        drive(1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq1_inst",      inst,               32'h1111_0000);
        chk("seq1_instPc",    instPc,             32'h0);
        chk("seq1_instValid", {31'd0, instValid}, 32'd1);
        chk("seq1_romAddr",   romAddr,            32'h4);
        chk("seq1_flush",     {31'd0, flush},     32'd0);
        $display("txn fetch addr=%h inst=%h", romAddr, inst);
        tick();

        // Stall for three cycles with a held response at 8.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1111_0008, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("stall_romAck",  {31'd0, romAck}, 32'd0);
            chk("stall_inst",    inst,            32'h1111_0004);
            chk("stall_instPc",  instPc,          32'h4);
            chk("stall_romAddr", romAddr,         32'h8);
            $display("txn stall cycle %0d romAddr=%h instPc=%h", i, romAddr, instPc);
            tick();
        end
        drive(1'b1, 32'h1111_0008, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("unstall_romAck", {31'd0, romAck}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq2_inst",    inst,            32'h1111_0008);
        chk("seq2_instPc",  instPc,          32'h8);
        chk("seq2_romAddr", romAddr,         32'hC);
        chk("seq2_romAck",  {31'd0, romAck}, 32'd0);
        $display("txn fetch addr=%h inst=%h", romAddr, inst);
        tick();
        drive(1'b1, 32'h1111_000C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("gap_instValid", {31'd0, instValid}, 32'd0);
        chk("seq3_romAddr",  romAddr,            32'hC);
        tick();

        // Jump while the request to 0x10 is outstanding.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("seq3_inst",   inst,    32'h1111_000C);
        chk("seq3_instPc", instPc,  32'hC);
        chk("j_romAddr",   romAddr, 32'h10);
        chk("j_romAck",    {31'd0, romAck}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("drop_flush",     {31'd0, flush},     32'd1);
        chk("drop_instValid", {31'd0, instValid}, 32'd0);
        chk("drop_romCe",     {31'd0, romCe},     32'd1);
        chk("drop_romAddr",   romAddr,            32'h10);
        $display("txn jump 0x100 pending, flush=%0b", flush);
        tick();
        drive(1'b1, 32'hDEAD_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("late_flush",  {31'd0, flush},  32'd0);
        chk("late_romAck", {31'd0, romAck}, 32'd1);
        tick();

        // Jump and exception together while 0x100 is outstanding: exception wins.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h80);
        chk("jt_romAddr",   romAddr,            32'h100);
        chk("jt_instValid", {31'd0, instValid}, 32'd0);
        tick();
        drive(1'b1, 32'hDEAD_0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("both_flush",  {31'd0, flush},  32'd1);
        chk("both_romAck", {31'd0, romAck}, 32'd1);
        tick();
        drive(1'b1, 32'h2222_0080, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("exc_romAddr", romAddr,        32'h80);
        chk("exc_flush",   {31'd0, flush}, 32'd0);
        $display("txn exception over jump, romAddr=%h", romAddr);
        tick();

        // Redirect on the same edge as a response: data dropped.
        drive(1'b1, 32'hBAD0_0084, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        chk("exc_inst",    inst,            32'h2222_0080);
        chk("exc_instPc",  instPc,          32'h80);
        chk("co_romAck",   {31'd0, romAck}, 32'd1);
        chk("co_romAddr0", romAddr,         32'h84);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("co_romAddr",   romAddr,            32'h300);
        chk("co_instValid", {31'd0, instValid}, 32'd0);
        chk("co_flush",     {31'd0, flush},     32'd1);
        $display("txn coincident redirect, romAddr=%h", romAddr);
        tick();

        // PC wrap: redirect to 0xFFFFFFFC, then sequential step to 0.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("wrap_flush0", {31'd0, flush}, 32'd0);
        tick();
        drive(1'b1, 32'hDEAD_0300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_flush1", {31'd0, flush},  32'd1);
        chk("wrap_ack300", {31'd0, romAck}, 32'd1);
        tick();
        drive(1'b1, 32'h3333_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_romAddrF", romAddr,         32'hFFFF_FFFC);
        chk("wrap_romAck",   {31'd0, romAck}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_romAddr0", romAddr,            32'h0);
        chk("wrap_instPc",   instPc,             32'hFFFF_FFFC);
        chk("wrap_inst",     inst,               32'h3333_FFFC);
        chk("wrap_valid",    {31'd0, instValid}, 32'd1);
        $display("txn wrap instPc=%h next romAddr=%h", instPc, romAddr);

`ifdef FETCH_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (!fetchErr && waited < 40) begin
                tick();
                waited++;
            end
            chk("to_fetchErr",  {31'd0, fetchErr},  32'd1);
            chk("to_romCe",     {31'd0, romCe},     32'd0);
            chk("to_instValid", {31'd0, instValid}, 32'd0);
            $display("txn timeout after %0d cycles", waited);
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
            tick();
            chk("err_jIgnored", {31'd0, fetchErr}, 32'd1);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
            tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("rec_fetchErr", {31'd0, fetchErr}, 32'd0);
            chk("rec_romAddr",  romAddr,           32'h40);
            chk("rec_romCe",    {31'd0, romCe},    32'd1);
            chk("rec_flush",    {31'd0, flush},    32'd1);
            $display("txn recover romAddr=%h", romAddr);
        end
`else
        for (int i = 0; i < 20; i++) tick();
        chk("wait_fetchErr", {31'd0, fetchErr}, 32'd0);
        chk("wait_romCe",    {31'd0, romCe},    32'd1);
        chk("wait_romAddr",  romAddr,           32'h0);
        $display("txn long wait fetchErr=%0b romCe=%0b", fetchErr, romCe);
`endif

        // Asynchronous reset between clock edges.
        #1;
        rst = 1'b0;
        #1;
        chk("arst_romCe",     {31'd0, romCe},     32'd0);
        chk("arst_instValid", {31'd0, instValid}, 32'd0);
        chk("arst_romAddr",   romAddr,            32'h0);
        $display("txn async reset romCe=%0b", romCe);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
